// File: rtl/regfile_wb.sv
// RV32I integer register file with write-back port and a one-deep load scoreboard.
// Optional same-cycle write/load-return bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_wb #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rv1,
  output logic [XLEN-1:0] rv2,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_rd,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  output logic            stall,
  output logic            busy
);

  localparam int NREG = 1 << AW;

  typedef enum logic {IDLE, PEND} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_pend_rd, w_pend_rd_nxt;
  logic            r_kill, w_kill_nxt;
  logic [XLEN-1:0] r_regs [NREG];

  logic            w_pend;
  logic            w_ld_commit;
  logic            w_rd_match;
  logic            w_use_hazard;

  assign w_pend      = (r_state == PEND);
  // Returned load data is written only if no younger write has claimed the register.
  assign w_ld_commit = w_pend && ld_valid && !r_kill && (r_pend_rd != '0);
  assign w_rd_match  = (r_pend_rd != '0) &&
                       ((rs1_addr == r_pend_rd) || (rs2_addr == r_pend_rd));

`ifdef REGFILE_BYPASS_EN
  assign w_use_hazard = w_pend && !ld_valid && w_rd_match;
`else
  assign w_use_hazard = w_pend && w_rd_match;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pend_rd <= '0;
      r_kill    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend_rd <= w_pend_rd_nxt;
      r_kill    <= w_kill_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pend_rd_nxt = r_pend_rd;
    w_kill_nxt    = r_kill;
    ld_ready      = 1'b0;
    busy          = 1'b0;
    stall         = w_use_hazard;
    case (r_state)
      IDLE: begin
        if (ld_issue) begin
          w_state_nxt   = PEND;
          w_pend_rd_nxt = ld_rd;
          w_kill_nxt    = 1'b0;
        end
      end
      PEND: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        // A second load cannot be accepted while one is in flight.
        if (ld_issue) stall = 1'b1;
        if (wr_en && (wr_addr == r_pend_rd)) w_kill_nxt = 1'b1;
        if (ld_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_en && (wr_addr == AW'(i))) begin
          r_regs[i] <= wr_data;
        end else if (w_ld_commit && (r_pend_rd == AW'(i))) begin
          r_regs[i] <= ld_data;
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // The ALU write-back is younger than the load, so it takes priority in the bypass.
  assign rv1 = (rs1_addr == '0)                            ? '0 :
               (wr_en && (wr_addr == rs1_addr))            ? wr_data :
               (w_ld_commit && (r_pend_rd == rs1_addr))    ? ld_data :
                                                             r_regs[rs1_addr];
  assign rv2 = (rs2_addr == '0)                            ? '0 :
               (wr_en && (wr_addr == rs2_addr))            ? wr_data :
               (w_ld_commit && (r_pend_rd == rs2_addr))    ? ld_data :
                                                             r_regs[rs2_addr];
`else
  assign rv1 = (rs1_addr == '0) ? '0 : r_regs[rs1_addr];
  assign rv2 = (rs2_addr == '0) ? '0 : r_regs[rs2_addr];
`endif

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Integer register file and write-back stage of the RV32I single-cycle core.
- Sits directly upstream of the R-type execute stage: drives its rv1/rv2 source operands and accepts its regdata_R result on the write port.
- Also tracks one outstanding multi-cycle load through a small scoreboard FSM. It stalls the core when an instruction reads a register whose load data has not yet returned.

Parameters:
XLEN, 32, data width of each register and of all data ports
AW, 5, register address width (2**AW registers; x0 hardwired to zero)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rs1_addr  input  AW  source register 1 index (instr[19:15])
rs2_addr  input  AW  source register 2 index (instr[24:20])
rv1  output  XLEN  source operand 1 to execute stages
rv2  output  XLEN  source operand 2 to execute stages
wr_en  input  1  single-cycle write-back strobe (R/I/U/JAL results)
wr_addr  input  AW  write-back destination index
wr_data  input  XLEN  write-back data (e.g. regdata_R)
ld_issue  input  1  load issued this cycle; its destination is ld_rd
ld_rd  input  AW  destination index of the issued load
ld_valid  input  1  load data returning this cycle
ld_data  input  XLEN  returned load data
ld_ready  output  1  scoreboard can accept ld_valid (state PEND)
stall  output  1  hold PC/decode this cycle
busy  output  1  a load is outstanding

Behaviour:
- Storage: 2**AW x XLEN registers. Async reset clears every register to 0 and FSM to IDLE; pend_rd=0, kill=0.
- Outputs during reset: rv1=rv2=0 from cleared storage; ld_ready=0, stall=0, busy=0.
- x0: rs*_addr==0 always reads 0. Writes to index 0 from either source are dropped.
- Reads are combinational (zero latency). Writes commit on the rising edge and are visible from the next cycle. A same-cycle read returns the new value only through the bypass (see Optional Feature).
- FSM states:
  - IDLE: ld_issue -> PEND; latch pend_rd=ld_rd, kill=0. If ld_rd==0, the load still occupies PEND but its data is discarded.
  - PEND: ld_ready=1, busy=1. On ld_valid, write ld_data to pend_rd unless kill=1 or pend_rd==0, then -> IDLE. ld_valid in IDLE is ignored.
- Only one load may be outstanding at a time.
- stall=1 when any of the following holds:
  - state==PEND, ld_valid==0, pend_rd!=0, and rs1_addr==pend_rd or rs2_addr==pend_rd.
  - state==PEND and ld_issue==1 (structural hazard). The issue is not accepted, the FSM stays in PEND, and the core must re-present it.
- Same cycle ld_valid and ld_issue in PEND: the return completes, the FSM goes to IDLE, and the new issue is still refused (stall=1). It is re-presented next cycle.
- WAW: a wr_en to wr_addr==pend_rd while in PEND sets kill=1. The older load's data is then discarded when it returns.
- Simultaneous wr_en and ld_valid:
  - Different addresses: both commit.
  - Same address: wr_data wins, because the ALU result is younger in program order.
- Reset mid-PEND: the FSM returns to IDLE and the outstanding load is forgotten. A late ld_valid is ignored.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - If wr_en && wr_addr!=0 && wr_addr==rsN_addr, then rvN=wr_data.
  - Otherwise, if PEND && ld_valid && !kill && pend_rd!=0 && pend_rd==rsN_addr, then rvN=ld_data.
  - Load-use stall clears in the data-return cycle (ld_valid qualifies stall as above).
- Undefined:
  - rvN always returns stored contents.
  - The load-use stall also covers the ld_valid cycle: drop the ld_valid==0 term.
  - Single-cycle write-backs need one cycle before the value is readable; the upstream control handles that hazard.

Test Plan:
- Reset then read all 32 indices -> rv1=rv2=0. Write 0xDEADBEEF to x0, read x0 -> 0.
- wr_en x5=0x00000007, next cycle rs1=x5, rs2=x5 -> rv1=rv2=0x00000007. With REGFILE_BYPASS_EN, the same cycle also returns 0x7.
- ld_issue rd=x3, then rs1=x3 for 3 cycles -> stall=1, busy=1, ld_ready=1. ld_valid with 0x12345678 -> x3=0x12345678, FSM IDLE, stall=0 after commit (same cycle with bypass).
- ld_issue rd=x4, then wr_en x4=0x11, then ld_valid with 0x22 -> x4 reads 0x11 (kill honoured).
- PEND with ld_issue asserted -> stall=1, FSM unchanged. ld_valid + wr_en both to pend_rd=x6, data 0xAA/0xBB -> x6=0xBB.
- Assert rst_n=0 mid-PEND, release, then ld_valid with 0x55 to former pend_rd -> register stays 0, busy=0, ld_ready=0.
